bus_gate_mux: RTL and testbench

Parametrised, registered replacement for the single 16-bit tri-state buffer on the processor datapath bus. It gates one of NSRC source words onto the shared bus with one-hot gate controls, registers the bus value, and optionally holds the last driven value when no gate is active. It also detects multi-driver contention, reports the first offending gate pattern, and counts contention events for debug.

---
 rtl/bus_gate_mux.sv | 128 ++++++++++++
 tb/tb_bus_gate_mux.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_gate_mux.sv
// bus_gate_mux: registered, parametrised replacement for a tri-state bus buffer.
// One of NSRC source words is gated onto a registered bus by one-hot gate controls.
// Simultaneous gates are resolved by fixed priority to the lowest index and flagged
// as contention. A sticky flag, the first offending pattern and a saturating event
// count are kept for debug.
//
// Parameters:
//   WIDTH  - bus / source word width in bits
//   NSRC   - number of sources
//   KEEP   - 1: hold last driven word when no gate is active; 0: drive zero
//   CNT_W  - contention counter width
// Ports:
//   clk             - clock, all state updates on rising edge
//   rst             - synchronous active-high reset
//   src_data        - packed source words, source i at [i*WIDTH +: WIDTH]
//   gate            - per-source gate enables (one-hot or zero expected)
//   err_clear       - clears contention flag, mask and counter
//   bus_out         - registered bus word
//   bus_valid       - registered; bus_out was driven by at least one gate
//   contention      - sticky multi-driver flag
//   contention_mask - gate pattern of the first contention since reset/clear
//   contention_cnt  - saturating contention cycle count
module bus_gate_mux #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NSRC  = 4,
  parameter bit          KEEP  = 1'b1,
  parameter int unsigned CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NSRC*WIDTH-1:0] src_data,
  input  logic [NSRC-1:0]       gate,
  input  logic                  err_clear,
  output logic [WIDTH-1:0]      bus_out,
  output logic                  bus_valid,
  output logic                  contention,
  output logic [NSRC-1:0]       contention_mask,
  output logic [CNT_W-1:0]      contention_cnt
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [WIDTH-1:0] sel_word;
  logic             any_gate;
  logic             multi_gate;

  logic [WIDTH-1:0] bus_q, bus_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic             valid_q, valid_d;
  logic             cont_q, cont_d;
  logic [NSRC-1:0]  mask_q, mask_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Scan from the top down so the lowest active index wins.
  always_comb begin
    sel_word = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (gate[i]) begin
        sel_word = src_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign any_gate   = |gate;
  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign multi_gate = |(gate & (gate - NSRC'(1)));

  always_comb begin
    bus_d   = bus_q;
    valid_d = 1'b0;
    last_d  = last_q;
    cont_d  = cont_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;

    if (any_gate) begin
      bus_d   = sel_word;
      valid_d = 1'b1;
      last_d  = sel_word;
    end else if (KEEP) begin
      bus_d = last_q;
    end else begin
      bus_d = '0;
    end

    if (multi_gate) begin
      // A contention event takes precedence over a simultaneous clear.
      cont_d = 1'b1;
      if (err_clear || !cont_q) begin
        mask_d = gate;
      end
      if (err_clear) begin
        cnt_d = CNT_W'(1);
      end else if (cnt_q != CntMax) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (err_clear) begin
      cont_d = 1'b0;
      mask_d = '0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_q   <= '0;
      last_q  <= '0;
      valid_q <= 1'b0;
      cont_q  <= 1'b0;
      mask_q  <= '0;
      cnt_q   <= '0;
    end else begin
      bus_q   <= bus_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      cont_q  <= cont_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus_out         = bus_q;
  assign bus_valid       = valid_q;
  assign contention      = cont_q;
  assign contention_mask = mask_q;
  assign contention_cnt  = cnt_q;

endmodule

// File: tb/tb_bus_gate_mux.sv
// Testbench for bus_gate_mux. Two instances share stimulus: inst A (KEEP=1, CNT_W=2)
// and inst B (KEEP=0, CNT_W=8). A behavioural model predicts both every cycle.
module tb_bus_gate_mux;

  localparam int W = 16;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N*W-1:0] src_data;
  logic [N-1:0] gate;
  logic         err_clear;

  logic [W-1:0] a_bus, b_bus;
  logic         a_valid, b_valid, a_cont, b_cont;
  logic [N-1:0] a_mask, b_mask;
  logic [1:0]   a_cnt;
  logic [7:0]   b_cnt;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  bus_gate_mux #(.WIDTH(W), .NSRC(N), .KEEP(1'b1), .CNT_W(2)) dut_a (
    .clk(clk), .rst(rst), .src_data(src_data), .gate(gate), .err_clear(err_clear),
    .bus_out(a_bus), .bus_valid(a_valid), .contention(a_cont),
    .contention_mask(a_mask), .contention_cnt(a_cnt)
  );

  bus_gate_mux #(.WIDTH(W), .NSRC(N), .KEEP(1'b0), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .src_data(src_data), .gate(gate), .err_clear(err_clear),
    .bus_out(b_bus), .bus_valid(b_valid), .contention(b_cont),
    .contention_mask(b_mask), .contention_cnt(b_cnt)
  );

  // Model state, index 0 = inst A, 1 = inst B.
  int m_bus[2], m_last[2], m_valid[2], m_cont[2], m_mask[2], m_cnt[2];
  int m_keep[2] = '{1, 0};
  int m_cmax[2] = '{3, 255};

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic int word_of(input int idx);
    return int'(src_data[idx*W +: W]);
  endfunction

  always @(posedge clk) begin
    int n;
    int lo;
    n  = $countones(gate);
    lo = 0;
    while (lo < N - 1 && !gate[lo]) lo++;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_bus[k] = 0; m_last[k] = 0; m_valid[k] = 0;
        m_cont[k] = 0; m_mask[k] = 0; m_cnt[k] = 0;
      end else begin
        if (n > 0) begin
          m_bus[k] = word_of(lo); m_last[k] = m_bus[k]; m_valid[k] = 1;
        end else begin
          m_bus[k] = (m_keep[k] != 0) ? m_last[k] : 0; m_valid[k] = 0;
        end
        if (n >= 2) begin
          if (err_clear) begin
            m_mask[k] = int'(gate); m_cnt[k] = 1;
          end else begin
            if (m_cont[k] == 0) m_mask[k] = int'(gate);
            if (m_cnt[k] < m_cmax[k]) m_cnt[k] = m_cnt[k] + 1;
          end
          m_cont[k] = 1;
        end else if (err_clear) begin
          m_cont[k] = 0; m_mask[k] = 0; m_cnt[k] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("a_bus", int'(a_bus), m_bus[0]);
      check("a_valid", int'(a_valid), m_valid[0]);
      check("a_cont", int'(a_cont), m_cont[0]);
      check("a_mask", int'(a_mask), m_mask[0]);
      check("a_cnt", int'(a_cnt), m_cnt[0]);
      check("b_bus", int'(b_bus), m_bus[1]);
      check("b_valid", int'(b_valid), m_valid[1]);
      check("b_cont", int'(b_cont), m_cont[1]);
      check("b_mask", int'(b_mask), m_mask[1]);
      check("b_cnt", int'(b_cnt), m_cnt[1]);
    end
  end

  // Apply current inputs across one rising edge; outputs are settled on return.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int idx, input logic [W-1:0] v);
    src_data[idx*W +: W] = v;
  endtask

  initial begin
    rst = 1'b1; gate = '0; err_clear = 1'b0;
    src_data = {$urandom, $urandom};
    cyc();
    chk_en = 1'b1;
    cyc();
    check("reset_bus", int'(a_bus), 0);
    check("reset_cnt", int'(a_cnt), 0);

    // Single transfer then idle.
    rst = 1'b0; gate = 4'b0001; set_src(0, 16'h04D2);
    cyc();
    check("single_bus", int'(a_bus), 'h04D2);
    check("single_valid", int'(a_valid), 1);
    check("single_cont", int'(a_cont), 0);
    gate = '0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("keep_bus", int'(a_bus), 'h04D2);
      check("keep_valid", int'(a_valid), 0);
      check("nokeep_bus", int'(b_bus), 0);
    end

    // Contention, mask from the first event only.
    gate = 4'b0110; set_src(1, 16'h0CAD); set_src(2, 16'hBEEF);
    cyc();
    check("multi_bus", int'(a_bus), 'h0CAD);
    check("multi_valid", int'(a_valid), 1);
    check("multi_cont", int'(a_cont), 1);
    check("multi_mask", int'(a_mask), 'b0110);
    check("multi_cnt", int'(a_cnt), 1);
    gate = 4'b1001;
    cyc();
    check("multi2_mask", int'(a_mask), 'b0110);
    check("multi2_cnt", int'(a_cnt), 2);

    // Clear without event, then clear with event.
    err_clear = 1'b1; gate = 4'b0001; set_src(0, 16'h1111);
    cyc();
    check("clr_cont", int'(a_cont), 0);
    check("clr_mask", int'(a_mask), 0);
    check("clr_cnt", int'(a_cnt), 0);
    check("clr_bus", int'(a_bus), 'h1111);
    gate = 4'b1100;
    cyc();
    check("clrev_cont", int'(a_cont), 1);
    check("clrev_mask", int'(a_mask), 'b1100);
    check("clrev_cnt", int'(a_cnt), 1);

    // Saturation of the 2-bit counter.
    gate = '0;
    cyc();
    err_clear = 1'b0; gate = 4'b0011;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("sat_cnt_a", int'(a_cnt), (i < 3) ? i + 1 : 3);
      check("sat_cnt_b", int'(b_cnt), i + 1);
      check("sat_cont", int'(a_cont), 1);
      check("sat_mask", int'(a_mask), 'b0011);
    end

    // Reset discards a word gated in the same cycle.
    rst = 1'b1; gate = 4'b0100; set_src(2, 16'h1234); err_clear = 1'b1;
    cyc();
    check("rst_bus", int'(a_bus), 0);
    check("rst_valid", int'(a_valid), 0);
    check("rst_cont", int'(a_cont), 0);
    rst = 1'b0; gate = '0; err_clear = 1'b0;
    cyc();
    check("cold_bus", int'(a_bus), 0);
    check("cold_valid", int'(a_valid), 0);

    // Randomized traffic checked by the model.
    for (int i = 0; i < 600; i++) begin
      int sel;
      src_data = {$urandom, $urandom};
      sel = int'($urandom_range(0, 9));
      if (sel < 3) gate = '0;
      else if (sel < 7) gate = N'(1) << $urandom_range(0, N - 1);
      else gate = N'($urandom);
      err_clear = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 49) == 0);
      cyc();
    end

    rst = 1'b0; gate = '0; err_clear = 1'b0;
    cyc();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
